// File: rtl/if_stage_pkg.sv
// Shared fetch-stage constants and the next-PC selection encoding.
package if_stage_pkg;

    localparam int unsigned PC_W    = 6;
    localparam int unsigned INSTR_W = 16;

    localparam logic [PC_W-1:0]    RESET_PC  = 6'd0;
    localparam logic [PC_W-1:0]    PC_INC    = 6'd2;
    localparam logic [INSTR_W-1:0] NOP_INSTR = 16'h0000;

    typedef enum logic [1:0] {
        SEL_HOLD,
        SEL_BRANCH,
        SEL_SEQ
    } pc_sel_e;

endpackage

// File: rtl/if_stage_if.sv
// Fetch-stage signal bundle: decode/hazard controls, instruction memory port, IF/ID outputs.
interface if_stage_if;
    import if_stage_pkg::*;

    logic               in_haz;
    logic               in_pc_src;
    logic [PC_W-1:0]    in_branch_tgt;
    logic [PC_W-1:0]    out_imem_addr;
    logic [INSTR_W-1:0] in_imem_data;
    logic [INSTR_W-1:0] out_instr;
    logic [PC_W-1:0]    out_pc_plus;
    logic               out_valid;
    logic               out_flush;
    logic [7:0]         out_stall_cnt;

    modport slave (
        input  in_haz, in_pc_src, in_branch_tgt, in_imem_data,
        output out_imem_addr, out_instr, out_pc_plus, out_valid, out_flush, out_stall_cnt
    );

    modport master (
        output in_haz, in_pc_src, in_branch_tgt, in_imem_data,
        input  out_imem_addr, out_instr, out_pc_plus, out_valid, out_flush, out_stall_cnt
    );

endinterface

// File: rtl/if_stage_if_id_reg.sv
// IF/ID pipeline register: holds on stall, loads a NOP bubble on squash, else captures fetch.
module if_id_reg
    import if_stage_pkg::*;
(
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               hold_i,
    input  logic               squash_i,
    input  logic [INSTR_W-1:0] instr_i,
    input  logic [PC_W-1:0]    pc_plus_i,
    output logic [INSTR_W-1:0] instr_o,
    output logic [PC_W-1:0]    pc_plus_o,
    output logic               valid_o
);

    logic [INSTR_W-1:0] instr_q;
    logic [PC_W-1:0]    pc_plus_q;
    logic               valid_q;

    always_ff @(posedge clk_i) begin
        if (rst_i || squash_i) begin
            instr_q   <= NOP_INSTR;
            pc_plus_q <= '0;
            valid_q   <= 1'b0;
        end else if (!hold_i) begin
            instr_q   <= instr_i;
            pc_plus_q <= pc_plus_i;
            valid_q   <= 1'b1;
        end
    end

    assign instr_o   = instr_q;
    assign pc_plus_o = pc_plus_q;
    assign valid_o   = valid_q;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, next-PC select, IF/ID register and a saturating stall counter.
module if_stage
    import if_stage_pkg::*;
(
    input  logic    CLOCK,
    input  logic    in_rst,
    if_stage_if.slave bus
);

    pc_sel_e         sel;
    logic [PC_W-1:0] pc_q, pc_d, pc_plus;
    logic            flush_q, flush_d;
    logic [7:0]      stall_cnt_q, stall_cnt_d;

    assign pc_plus = pc_q + PC_INC;

    // Hazard outranks redirect: branch operands in decode are stale while stalled.
    always_comb begin
        sel = SEL_SEQ;
        if (bus.in_haz)
            sel = SEL_HOLD;
        else if (bus.in_pc_src)
            sel = SEL_BRANCH;
    end

    always_comb begin
        pc_d        = pc_plus;
        flush_d     = 1'b0;
        stall_cnt_d = stall_cnt_q;
        case (sel)
            SEL_HOLD: begin
                pc_d = pc_q;
                if (stall_cnt_q != 8'hFF)
                    stall_cnt_d = stall_cnt_q + 8'd1;
            end
            SEL_BRANCH: begin
                pc_d    = {bus.in_branch_tgt[PC_W-1:1], 1'b0};
                flush_d = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLOCK) begin
        if (in_rst) begin
            pc_q        <= RESET_PC;
            flush_q     <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            pc_q        <= pc_d;
            flush_q     <= flush_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    if_id_reg u_if_id (
        .clk_i     (CLOCK),
        .rst_i     (in_rst),
        .hold_i    (sel == SEL_HOLD),
        .squash_i  (sel == SEL_BRANCH),
        .instr_i   (bus.in_imem_data),
        .pc_plus_i (pc_plus),
        .instr_o   (bus.out_instr),
        .pc_plus_o (bus.out_pc_plus),
        .valid_o   (bus.out_valid)
    );

    assign bus.out_imem_addr = pc_q;
    assign bus.out_flush     = flush_q;
    assign bus.out_stall_cnt = stall_cnt_q;

endmodule
